// File: rtl/mod12_seq_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod12_seq_monitor_if
//  Description : Sample bus between a mod-12 counter front end and the
//                sequence monitor.
//                master : drives en, M, q, qb; observes the monitor status
//                slave  : the monitor itself
//                Signals:
//                  en       sample valid
//                  M        direction of the step ending at this sample (1=down)
//                  q        counter state
//                  qb       counter complement rail
//                  locked   monitor tracking
//                  carry    up-wrap pulse
//                  borrow   down-wrap pulse
//                  err      sequence / code error pulse
//                  err_cnt  saturating error count
//                  wrap_cnt signed net wrap count
//  Revision    : 1.0  initial release
// ============================================================================
interface mod12_seq_monitor_if #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
);
  logic              en;
  logic              M;
  logic [3:0]        q;
  logic [3:0]        qb;
  logic              locked;
  logic              carry;
  logic              borrow;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;

  modport master (
    output en, M, q, qb,
    input  locked, carry, borrow, err, err_cnt, wrap_cnt
  );

  modport slave (
    input  en, M, q, qb,
    output locked, carry, borrow, err, err_cnt, wrap_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mod12_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : mod12_seq_monitor
//  Description : Sequence monitor for a mod-MOD up/down counter. Each valid
//                sample is compared with the successor of the previous
//                sample for the applied direction. Produces registered
//                carry/borrow pulses on confirmed wraps, a signed net wrap
//                count, an error pulse and a saturating error count.
//                Ports:
//                  clk  rising-edge clock (same as the counter)
//                  rst  synchronous active-high reset
//                  mon  slave side of mod12_seq_monitor_if
//                Optional feature macro: QB_CHECK_EN
//                  defined   -> qb != ~q on a valid sample is a rail fault,
//                               handled exactly like an illegal code
//                  undefined -> qb is ignored
//                Latency: a sample presented at edge N is captured at edge N
//                and its response is visible after edge N+1.
//  Revision    : 1.0  initial release
// ============================================================================
module mod12_seq_monitor #(
  parameter int MOD    = 12,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mod12_seq_monitor_if.slave    mon
);

  localparam logic [3:0] C_MAX = 4'(MOD - 1);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    TRACK  = 2'd2
  } state_t;

  // Input capture stage
  logic       r_en;
  logic       r_m;
  logic [3:0] r_q;

  // Tracking state
  state_t     r_state;
  state_t     w_state_n;
  logic [3:0] r_prev;
  logic [3:0] w_prev_n;

  // Registered outputs
  logic              r_locked;
  logic              r_carry;
  logic              r_borrow;
  logic              r_err;
  logic [ERR_W-1:0]  r_err_cnt;
  logic [WRAP_W-1:0] r_wrap_cnt;

  logic       w_carry_n;
  logic       w_borrow_n;
  logic       w_err_n;
  logic       w_legal;
  logic       w_rail_ok;
  logic       w_ok;
  logic [3:0] w_exp;
  logic       w_match;

`ifdef QB_CHECK_EN
  logic [3:0] r_qb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_qb <= 4'hF;
    end else begin
      r_qb <= mon.qb;
    end
  end

  assign w_rail_ok = (r_qb == ~r_q);
`else
  logic unused_qb;
  assign unused_qb = ^mon.qb;
  assign w_rail_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en <= 1'b0;
      r_m  <= 1'b0;
      r_q  <= 4'd0;
    end else begin
      r_en <= mon.en;
      r_m  <= mon.M;
      r_q  <= mon.q;
    end
  end

  assign w_legal = (r_q <= C_MAX);
  // A rail fault makes an otherwise legal code count as illegal.
  assign w_ok    = w_legal && w_rail_ok;
  assign w_exp   = r_m ? ((r_prev == 4'd0) ? C_MAX : r_prev - 4'd1)
                       : ((r_prev == C_MAX) ? 4'd0 : r_prev + 4'd1);
  assign w_match = w_ok && (r_q == w_exp);

  always_comb begin
    w_state_n  = r_state;
    w_prev_n   = r_prev;
    w_carry_n  = 1'b0;
    w_borrow_n = 1'b0;
    w_err_n    = 1'b0;
    if (r_en) begin
      case (r_state)
        ACQ: begin
          if (w_ok) begin
            w_prev_n  = r_q;
            w_state_n = VERIFY;
          end else begin
            w_err_n = 1'b1;
          end
        end
        VERIFY, TRACK: begin
          if (w_match) begin
            w_prev_n   = r_q;
            w_state_n  = TRACK;
            w_carry_n  = !r_m && (r_prev == C_MAX) && (r_q == 4'd0);
            w_borrow_n =  r_m && (r_prev == 4'd0)  && (r_q == C_MAX);
          end else if (w_ok) begin
            w_err_n   = 1'b1;
            w_prev_n  = r_q;
            w_state_n = VERIFY;
          end else begin
            w_err_n   = 1'b1;
            w_state_n = ACQ;
          end
        end
        default: begin
          w_state_n = ACQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACQ;
      r_prev     <= 4'd0;
      r_locked   <= 1'b0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_state  <= w_state_n;
      r_prev   <= w_prev_n;
      r_locked <= (w_state_n == TRACK);
      r_carry  <= w_carry_n;
      r_borrow <= w_borrow_n;
      r_err    <= w_err_n;
      if (w_err_n && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      // Modular on purpose: the count is a two's-complement net value.
      if (w_carry_n) begin
        r_wrap_cnt <= r_wrap_cnt + 1'b1;
      end else if (w_borrow_n) begin
        r_wrap_cnt <= r_wrap_cnt - 1'b1;
      end
    end
  end

  assign mon.locked   = r_locked;
  assign mon.carry    = r_carry;
  assign mon.borrow   = r_borrow;
  assign mon.err      = r_err;
  assign mon.err_cnt  = r_err_cnt;
  assign mon.wrap_cnt = r_wrap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mod12_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod12_seq_monitor
//  Description : Directed table-driven bench for mod12_seq_monitor plus a
//                back-to-back sampling sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod12_seq_monitor;

  logic clk;
  logic rst;

  mod12_seq_monitor_if #(.WRAP_W(8), .ERR_W(4)) bus ();

  mod12_seq_monitor #(.MOD(12), .WRAP_W(8), .ERR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       m;
    logic [3:0] q;
    logic [3:0] qb_flip;
    logic       locked;
    logic       carry;
    logic       borrow;
    logic       err;
    logic [3:0] err_cnt;
    logic [7:0] wrap_cnt;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic add(input string name, input logic r, input logic en, input logic m,
                     input logic [3:0] q, input logic [3:0] flip,
                     input logic lk, input logic c, input logic b, input logic e,
                     input logic [3:0] ec, input logic [7:0] wc);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.m = m; v.q = q; v.qb_flip = flip;
    v.locked = lk; v.carry = c; v.borrow = b; v.err = e;
    v.err_cnt = ec; v.wrap_cnt = wc;
    tbl.push_back(v);
  endtask

  task automatic check_outputs(input string name, input logic lk, input logic c,
                               input logic b, input logic e, input logic [3:0] ec,
                               input logic [7:0] wc);
    chk({name, ".locked"},   int'(bus.locked),   int'(lk));
    chk({name, ".carry"},    int'(bus.carry),    int'(c));
    chk({name, ".borrow"},   int'(bus.borrow),   int'(b));
    chk({name, ".err"},      int'(bus.err),      int'(e));
    chk({name, ".err_cnt"},  int'(bus.err_cnt),  int'(ec));
    chk({name, ".wrap_cnt"}, int'(bus.wrap_cnt), int'(wc));
  endtask

  initial begin
    logic       rail_on;
    logic [3:0] ec;
    logic [3:0] bb_q[4];
    logic       bb_lk[5];
    logic       bb_c[5];
    logic [7:0] bb_wc[5];

`ifdef QB_CHECK_EN
    rail_on = 1'b1;
`else
    rail_on = 1'b0;
`endif

    // ---------------- table fill ----------------
    // name      rst en M  q   flip  lk c  b  e  ec wc
    add("t1_q0",   0, 1, 0, 0,  0,   0, 0, 0, 0, 0, 8'h00);
    add("t1_q1",   0, 1, 0, 1,  0,   1, 0, 0, 0, 0, 8'h00);
    for (int i = 2; i <= 11; i++)
      add("t1_up", 0, 1, 0, 4'(i), 0, 1, 0, 0, 0, 0, 8'h00);
    add("t1_wrap", 0, 1, 0, 0,  0,   1, 1, 0, 0, 0, 8'h01);
    add("t1_post", 0, 1, 0, 1,  0,   1, 0, 0, 0, 0, 8'h01);

    add("t2_rst",  1, 0, 0, 0,  0,   0, 0, 0, 0, 0, 8'h00);
    add("t2_acq",  0, 1, 0, 1,  0,   0, 0, 0, 0, 0, 8'h00);
    add("t2_v0",   0, 1, 1, 0,  0,   1, 0, 0, 0, 0, 8'h00);
    add("t2_brw",  0, 1, 1, 11, 0,   1, 0, 1, 0, 0, 8'hFF);
    add("t2_q10",  0, 1, 1, 10, 0,   1, 0, 0, 0, 0, 8'hFF);
    add("t2_rev",  0, 1, 0, 11, 0,   1, 0, 0, 0, 0, 8'hFF);
    add("t2_cry",  0, 1, 0, 0,  0,   1, 1, 0, 0, 0, 8'h00);

    add("t3_rst",  1, 0, 0, 0,  0,   0, 0, 0, 0, 0, 8'h00);
    add("t3_q4",   0, 1, 0, 4,  0,   0, 0, 0, 0, 0, 8'h00);
    add("t3_q5",   0, 1, 0, 5,  0,   1, 0, 0, 0, 0, 8'h00);
    add("t3_q7",   0, 1, 0, 7,  0,   0, 0, 0, 1, 1, 8'h00);
    add("t3_q8",   0, 1, 0, 8,  0,   1, 0, 0, 0, 1, 8'h00);

    add("t4_q13",  0, 1, 0, 13, 0,   0, 0, 0, 1, 2, 8'h00);
    add("t4_q3",   0, 1, 0, 3,  0,   0, 0, 0, 0, 2, 8'h00);
    add("t4_q4",   0, 1, 0, 4,  0,   1, 0, 0, 0, 2, 8'h00);
    ec = 4'd2;
    for (int i = 0; i < 20; i++) begin
      if (ec != 4'd15) ec = ec + 4'd1;
      add("t4_sat", 0, 1, 0, (i % 2 == 0) ? 4'd12 : 4'd15, 0, 0, 0, 0, 1, ec, 8'h00);
    end

    add("t5_q3",   0, 1, 0, 3,  0,   0, 0, 0, 0, 15, 8'h00);
    add("t5_q4",   0, 1, 0, 4,  0,   1, 0, 0, 0, 15, 8'h00);
    add("t5_idle", 0, 0, 0, 9,  0,   1, 0, 0, 0, 15, 8'h00);
    add("t5_idle", 0, 0, 1, 1,  0,   1, 0, 0, 0, 15, 8'h00);
    add("t5_idle", 0, 0, 0, 13, 0,   1, 0, 0, 0, 15, 8'h00);
    add("t5_hold", 0, 1, 0, 5,  0,   1, 0, 0, 0, 15, 8'h00);
    add("t5_rst",  1, 1, 0, 7,  0,   0, 0, 0, 0, 0, 8'h00);

    add("t6_lk11", 0, 1, 0, 10, 0,   0, 0, 0, 0, 0, 8'h00);
    add("t6_lk11", 0, 1, 0, 11, 0,   1, 0, 0, 0, 0, 8'h00);
    if (rail_on) begin
      add("t6_rail", 0, 1, 0, 0, 4'b0001, 0, 0, 0, 1, 1, 8'h00);
      add("t6_next", 0, 1, 0, 1, 0,       0, 0, 0, 0, 1, 8'h00);
    end else begin
      add("t6_rail", 0, 1, 0, 0, 4'b0001, 1, 1, 0, 0, 0, 8'h01);
      add("t6_next", 0, 1, 0, 1, 0,       1, 0, 0, 0, 0, 8'h01);
    end

    // ---------------- reset state ----------------
    rst = 1'b1; bus.en = 1'b0; bus.M = 1'b0; bus.q = 4'd0; bus.qb = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 0, 0, 4'd0, 8'h00);
    rst = 1'b0;

    // ---------------- table ----------------
    // Each vector: present the sample for one edge, then one idle edge,
    // then check the response (visible after the second edge).
    foreach (tbl[i]) begin
      rst    = tbl[i].rst;
      bus.en = tbl[i].en;
      bus.M  = tbl[i].m;
      bus.q  = tbl[i].q;
      bus.qb = ~tbl[i].q ^ tbl[i].qb_flip;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      check_outputs(tbl[i].name, tbl[i].locked, tbl[i].carry, tbl[i].borrow,
                    tbl[i].err, tbl[i].err_cnt, tbl[i].wrap_cnt);
    end

    // ---------------- back-to-back samples ----------------
    rst = 1'b1; bus.en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bb_q[0] = 4'd10; bb_q[1] = 4'd11; bb_q[2] = 4'd0; bb_q[3] = 4'd1;
    bb_lk[0] = 0; bb_c[0] = 0; bb_wc[0] = 8'h00;
    bb_lk[1] = 0; bb_c[1] = 0; bb_wc[1] = 8'h00;
    bb_lk[2] = 1; bb_c[2] = 0; bb_wc[2] = 8'h00;
    bb_lk[3] = 1; bb_c[3] = 1; bb_wc[3] = 8'h01;
    bb_lk[4] = 1; bb_c[4] = 0; bb_wc[4] = 8'h01;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.en = 1'b1; bus.M = 1'b0; bus.q = bb_q[i]; bus.qb = ~bb_q[i];
      end else begin
        bus.en = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("b2b.locked",   int'(bus.locked),   int'(bb_lk[i]));
      chk("b2b.carry",    int'(bus.carry),    int'(bb_c[i]));
      chk("b2b.wrap_cnt", int'(bus.wrap_cnt), int'(bb_wc[i]));
      chk("b2b.err",      int'(bus.err),      0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
